// File: rtl/qbus_dma_arbiter.sv
// Bus-mastership arbiter for the 1801VM1 system bus: shares the bus between the CPU
// and NREQ DMA requesters via the DMR/DMGO/SACK handshake, round-robin, with offer timeout.
module qbus_dma_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 63
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_ce,
    input  logic            i_cpu_bsy,
    input  logic [NREQ-1:0] i_dmr,
    input  logic [NREQ-1:0] i_sack,
    output logic [NREQ-1:0] o_dmgo,
    output logic            o_cpu_hold,
    output logic            o_dma_active,
    output logic [2:0]      o_owner,
    output logic            o_grant_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CPU,
        OFFER,
        OWNED,
        RELEASE
    } state_t;

    localparam logic [2:0]      LAST_IDX  = 3'(NREQ - 1);
    localparam logic [7:0]      TIMER_TOP = 8'(TIMEOUT);
    localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

    state_t          r_state;
    logic [7:0]      r_timer;
    logic [2:0]      r_rrPtr;
    logic [2:0]      r_owner;
    logic [NREQ-1:0] r_dmgo;
    logic            r_cpuHold;
    logic            r_dmaActive;
    logic            r_grantErr;

    logic [NREQ-1:0] w_ownerOh;
    logic            w_dmrOwn;
    logic            w_sackOwn;
    logic [2:0]      w_nextPtr;
    logic            w_hiFound;
    logic [2:0]      w_hiIdx;
    logic [2:0]      w_loIdx;
    logic [2:0]      w_winner;

    // Select the owner's bit with a mask so the 3-bit owner never indexes past NREQ.
    assign w_ownerOh = ONE_HOT0 << r_owner;
    assign w_dmrOwn  = |(i_dmr & w_ownerOh);
    assign w_sackOwn = |(i_sack & w_ownerOh);
    assign w_nextPtr = (r_owner >= LAST_IDX) ? 3'd0 : r_owner + 3'd1;

    // Round-robin pick: lowest request at or above rr_ptr, else lowest request overall (wrap).
    always_comb begin
        w_hiFound = 1'b0;
        w_hiIdx   = 3'd0;
        w_loIdx   = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_dmr[i]) begin
                w_loIdx = 3'(i);
                if (3'(i) >= r_rrPtr) begin
                    w_hiFound = 1'b1;
                    w_hiIdx   = 3'(i);
                end
            end
        end
        w_winner = w_hiFound ? w_hiIdx : w_loIdx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= 8'd0;
            r_rrPtr     <= 3'd0;
            r_owner     <= 3'd0;
            r_dmgo      <= '0;
            r_cpuHold   <= 1'b0;
            r_dmaActive <= 1'b0;
            r_grantErr  <= 1'b0;
        end else if (i_ce) begin
            r_grantErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|i_dmr) begin
                        r_cpuHold <= 1'b1;
                        r_owner   <= w_winner;
                        r_state   <= WAIT_CPU;
                    end
                end
                // The CPU cycle in flight always completes; we only offer between cycles.
                WAIT_CPU: begin
                    if (!w_dmrOwn) begin
                        r_cpuHold <= 1'b0;
                        r_state   <= IDLE;
                    end else if (!i_cpu_bsy) begin
                        r_dmgo  <= w_ownerOh;
                        r_timer <= TIMER_TOP;
                        r_state <= OFFER;
                    end
                end
                OFFER: begin
                    if (w_sackOwn) begin
                        r_dmgo      <= '0;
                        r_dmaActive <= 1'b1;
                        r_state     <= OWNED;
                    end else if (!w_dmrOwn) begin
                        r_dmgo    <= '0;
                        r_cpuHold <= 1'b0;
                        r_state   <= IDLE;
                    end else if (r_timer == 8'd0) begin
                        // Skip past a dead requester so it cannot starve the others.
                        r_dmgo     <= '0;
                        r_cpuHold  <= 1'b0;
                        r_grantErr <= 1'b1;
                        r_rrPtr    <= w_nextPtr;
                        r_state    <= IDLE;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                OWNED: begin
                    if (!w_sackOwn) begin
                        r_dmaActive <= 1'b0;
                        r_rrPtr     <= w_nextPtr;
                        r_state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_cpuHold <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_dmgo      <= '0;
                    r_cpuHold   <= 1'b0;
                    r_dmaActive <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_dmgo       = r_dmgo;
    assign o_cpu_hold   = r_cpuHold;
    assign o_dma_active = r_dmaActive;
    assign o_owner      = r_owner;
    assign o_grant_err  = r_grantErr;

    // Handshake invariants the CPU interface relies on.
    assert property (@(posedge clk) disable iff (reset) $onehot0(r_dmgo));
    assert property (@(posedge clk) disable iff (reset) !((|r_dmgo) && r_dmaActive));
    assert property (@(posedge clk) disable iff (reset) ((|r_dmgo) || r_dmaActive) |-> r_cpuHold);

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Directed self-checking bench for qbus_dma_arbiter (NREQ=2, TIMEOUT=5).
module tb_qbus_dma_arbiter;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       cpuBsy;
    logic [1:0] dmr;
    logic [1:0] sack;
    logic [1:0] dmgo;
    logic       cpuHold;
    logic       dmaActive;
    logic [2:0] owner;
    logic       grantErr;

    int assertCount = 0;
    int failCount   = 0;

    qbus_dma_arbiter #(.NREQ(2), .TIMEOUT(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_ce        (ce),
        .i_cpu_bsy   (cpuBsy),
        .i_dmr       (dmr),
        .i_sack      (sack),
        .o_dmgo      (dmgo),
        .o_cpu_hold  (cpuHold),
        .o_dma_active(dmaActive),
        .o_owner     (owner),
        .o_grant_err (grantErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] newDmr, input logic [1:0] newSack, input logic newBsy);
        dmr    = newDmr;
        sack   = newSack;
        cpuBsy = newBsy;
    endtask

    // Advance n clocks; outputs are then sampled 1ns after the last edge.
    task automatic stepTicks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] expDmgo, input logic expHold,
                            input logic expActive, input logic expErr);
        checkOutput({tag, ".dmgo"}, 32'(dmgo), 32'(expDmgo));
        checkOutput({tag, ".hold"}, 32'(cpuHold), 32'(expHold));
        checkOutput({tag, ".active"}, 32'(dmaActive), 32'(expActive));
        checkOutput({tag, ".err"}, 32'(grantErr), 32'(expErr));
    endtask

    initial begin
        logic [2:0] expOwner;
        reset = 1'b1;
        ce    = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b0);
        stepTicks(2);
        checkAll("reset", 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.owner", 32'(owner), 32'd0);
        reset = 1'b0;

        // Single grant to requester 0.
        applyStimulus(2'b01, 2'b00, 1'b0);
        stepTicks(1);
        checkAll("single.t1", 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("single.owner", 32'(owner), 32'd0);
        stepTicks(1);
        checkAll("single.t2", 2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b01, 1'b0);
        stepTicks(1);
        checkAll("single.sack", 2'b00, 1'b1, 1'b1, 1'b0);
        stepTicks(1);
        checkAll("single.owned", 2'b00, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b0);
        stepTicks(1);
        checkAll("single.rel", 2'b00, 1'b1, 1'b0, 1'b0);
        stepTicks(1);
        checkAll("single.idle", 2'b00, 1'b0, 1'b0, 1'b0);

        // CPU busy stalls the offer; rr_ptr is now 1.
        applyStimulus(2'b10, 2'b00, 1'b1);
        stepTicks(1);
        checkOutput("busy.owner", 32'(owner), 32'd1);
        for (int k = 0; k < 10; k++) begin
            checkAll("busy.hold", 2'b00, 1'b1, 1'b0, 1'b0);
            stepTicks(1);
        end
        applyStimulus(2'b10, 2'b00, 1'b0);
        stepTicks(1);
        checkAll("busy.offer", 2'b10, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 2'b10, 1'b0);
        stepTicks(1);
        checkAll("busy.owned", 2'b00, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b0);
        stepTicks(2);
        checkAll("busy.idle", 2'b00, 1'b0, 1'b0, 1'b0);

        // Round-robin with both requests held; rr_ptr is 0 again.
        for (int g = 0; g < 4; g++) begin
            expOwner = 3'(g % 2);
            applyStimulus(2'b11, 2'b00, 1'b0);
            stepTicks(1);
            checkOutput("rr.owner", 32'(owner), 32'(expOwner));
            stepTicks(1);
            checkOutput("rr.dmgo", 32'(dmgo), 32'(2'b01 << expOwner));
            applyStimulus(2'b11, 2'(2'b01 << expOwner), 1'b0);
            stepTicks(1);
            checkOutput("rr.active", 32'(dmaActive), 32'd1);
            applyStimulus(2'b11, 2'b00, 1'b0);
            stepTicks(2);
            checkOutput("rr.holdlow", 32'(cpuHold), 32'd0);
        end
        applyStimulus(2'b00, 2'b00, 1'b0);
        stepTicks(1);

        // Offer timeout: dmgo held 6 ticks, then a one-tick grant_err; requester 1 goes next.
        applyStimulus(2'b01, 2'b00, 1'b0);
        stepTicks(1);
        applyStimulus(2'b11, 2'b00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            stepTicks(1);
            checkAll("tmo.offer", 2'b01, 1'b1, 1'b0, 1'b0);
        end
        stepTicks(1);
        checkAll("tmo.err", 2'b00, 1'b0, 1'b0, 1'b1);
        stepTicks(1);
        checkAll("tmo.next", 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("tmo.owner", 32'(owner), 32'd1);
        stepTicks(1);
        checkOutput("tmo.dmgo1", 32'(dmgo), 32'(2'b10));
        applyStimulus(2'b00, 2'b00, 1'b0);
        stepTicks(1);
        checkAll("tmo.withdraw", 2'b00, 1'b0, 1'b0, 1'b0);

        // Withdrawal during OFFER and foreign sack ignored.
        applyStimulus(2'b01, 2'b00, 1'b0);
        stepTicks(2);
        checkAll("wd.offer", 2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b10, 1'b0);
        stepTicks(1);
        checkAll("wd.foreign", 2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b0);
        stepTicks(1);
        checkAll("wd.idle", 2'b00, 1'b0, 1'b0, 1'b0);
        stepTicks(1);
        checkAll("wd.noerr", 2'b00, 1'b0, 1'b0, 1'b0);

        // ce gating and asynchronous reset mid-OWNED; rr_ptr was 1 beforehand.
        applyStimulus(2'b01, 2'b00, 1'b0);
        stepTicks(2);
        applyStimulus(2'b01, 2'b01, 1'b0);
        stepTicks(1);
        checkAll("rst.owned", 2'b00, 1'b1, 1'b1, 1'b0);
        ce = 1'b0;
        applyStimulus(2'b00, 2'b00, 1'b0);
        stepTicks(2);
        checkAll("ce.hold", 2'b00, 1'b1, 1'b1, 1'b0);
        ce = 1'b1;
        applyStimulus(2'b01, 2'b01, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkAll("rst.async", 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("rst.owner", 32'(owner), 32'd0);
        stepTicks(1);
        applyStimulus(2'b11, 2'b00, 1'b0);
        reset = 1'b0;
        stepTicks(1);
        checkOutput("rst.reowner", 32'(owner), 32'd0);
        checkOutput("rst.rehold", 32'(cpuHold), 32'd1);
        stepTicks(1);
        checkOutput("rst.redmgo", 32'(dmgo), 32'(2'b01));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
